// File: rtl/ram_mover_pkg.sv
// Shared types and constants for the RAM block mover.
package ram_mover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  localparam int LEN_DEFAULT = 1024;

endpackage

// File: rtl/ram_mover_addr_gen.sv
// Loadable up/down word-address counter with remaining-word count; last flags the final word.
// Address holds on the final step so it never walks outside the block.
module ram_mover_addr_gen #(
  parameter int CNT_W = 11
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             down,
  input  logic [31:0]      base,
  input  logic [CNT_W-1:0] cnt,
  input  logic             step,
  output logic [31:0]      addr,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] remain;
  logic             down_r;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr   <= 32'd0;
      remain <= '0;
      down_r <= 1'b0;
    end else if (load) begin
      down_r <= down;
      remain <= cnt;
      addr   <= down ? (base + 32'(cnt) - 32'd1) : base;
    end else if (step && (remain != '0)) begin
      remain <= remain - ONE;
      if (remain != ONE) begin
        addr <= down_r ? (addr - 32'd1) : (addr + 32'd1);
      end
    end
  end

  assign last = (remain == ONE);

endmodule

// File: rtl/ram_block_mover.sv
// Block copy/fill engine over one read and one write RAM port, one word per cycle, memmove-safe.
// Optional fill datapath under RAM_MOVER_FILL_EN; without it op=fill is rejected.
module ram_block_mover
  import ram_mover_pkg::*;
#(
  parameter int LEN   = LEN_DEFAULT,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ram_en,
  output logic [31:0]      ram_raddr,
  input  logic [31:0]      ram_q,
  output logic             ram_we,
  output logic [31:0]      ram_waddr,
  output logic [31:0]      ram_wdata
);

  state_t      state;
  logic        fill_cmd;
  logic        op_bad;
  logic        run_fill;
  logic [31:0] wdata_next;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        reject;
  logic        zero_len;
  logic        accept;
  logic        down;
  logic        in_run;
  logic [31:0] dst_cur;
  logic        src_last;
  logic        dst_last;
  logic        run_last;

  // Range checks are 33 bits wide so base + count cannot wrap past zero.
  assign src_end  = {1'b0, src_addr} + 33'(count);
  assign dst_end  = {1'b0, dst_addr} + 33'(count);
  assign zero_len = (count == '0);
  assign reject   = op_bad || (dst_end > 33'(LEN)) || (!fill_cmd && (src_end > 33'(LEN)));
  assign accept   = (state == IDLE) && start && !zero_len && !reject;
  assign down     = !fill_cmd && (dst_addr > src_addr);
  assign in_run   = (state == RUN);
  assign run_last = src_last | dst_last;
  assign ram_en   = busy;

`ifdef RAM_MOVER_FILL_EN
  logic [31:0] fill_val_r;
  logic        fill_r;

  assign fill_cmd = (op == OP_FILL);
  assign op_bad   = 1'b0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fill_r     <= 1'b0;
      fill_val_r <= 32'd0;
    end else if (accept) begin
      fill_r     <= fill_cmd;
      fill_val_r <= fill_value;
    end
  end

  assign run_fill   = fill_r;
  assign wdata_next = fill_r ? fill_val_r : ram_q;
`else
  logic unused_fill;

  assign fill_cmd    = 1'b0;
  assign op_bad      = (op == OP_FILL);
  assign run_fill    = 1'b0;
  assign wdata_next  = ram_q;
  assign unused_fill = ^fill_value;
`endif

  // The source counter stays idle during a fill, so the read port is never exercised.
  ram_mover_addr_gen #(.CNT_W(CNT_W)) u_src (
    .clock  (clock),
    .resetn (resetn),
    .load   (accept && !fill_cmd),
    .down   (down),
    .base   (src_addr),
    .cnt    (count),
    .step   (in_run && !run_fill),
    .addr   (ram_raddr),
    .last   (src_last)
  );

  ram_mover_addr_gen #(.CNT_W(CNT_W)) u_dst (
    .clock  (clock),
    .resetn (resetn),
    .load   (accept),
    .down   (down),
    .base   (dst_addr),
    .cnt    (count),
    .step   (in_run),
    .addr   (dst_cur),
    .last   (dst_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_we    <= 1'b0;
      ram_waddr <= 32'd0;
      ram_wdata <= 32'd0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (zero_len || reject) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= !zero_len;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Each read lands in the write register and is written one cycle later.
          ram_we    <= 1'b1;
          ram_waddr <= dst_cur;
          ram_wdata <= wdata_next;
          if (run_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_block_mover.md
# ram_block_mover

Autonomous initiator that drives two ports of the shared multi-port word RAM to move a block of words from one region to another, or optionally to fill a region with a constant. It sits beside the compute datapath and owns one combinational-read port and one write port of the RAM. It accepts one command at a time through a start/busy/done handshake, with memmove semantics for overlapping regions.

## Interface

- `LEN`, 1024: RAM depth in 32-bit words; all addresses must fall below it.
- `CNT_W`, `$clog2(LEN+1)`: width of the word-count field.

- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = copy, 1 = fill.
- `src_addr`  in  32  first source word (copy only).
- `dst_addr`  in  32  first destination word.
- `count`  in  CNT_W  number of words to move.
- `fill_value`  in  32  constant for fill.
- `busy`  out  1  high from the cycle after start is accepted until the cycle before done.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: the command was rejected and no RAM access was made.
- `ram_en`  out  1  RAM enable.
- `ram_raddr`  out  32  read-port address.
- `ram_q`  in  32  read-port data, combinational from `ram_raddr`.
- `ram_we`  out  1  write-port enable.
- `ram_waddr`  out  32  write-port address.
- `ram_wdata`  out  32  write-port data.

## Operation

- States are IDLE, RUN, DRAIN and DONE.
- **IDLE:** a command is latched when `start` is high.
  - If `count` is 0, go to DONE with `err` = 0.
  - If `dst_addr + count > LEN`, or if `op` = copy and `src_addr + count > LEN`, go to DONE with `err` = 1. Compute these checks 33 bits wide so they cannot wrap.
  - Otherwise go to RUN.
- **Direction:** for a copy with `dst_addr > src_addr`, addresses walk descending from `base + count - 1`. In every other case (including fill) they walk ascending from `base`. This makes overlapping copies correct.
- **RUN:** each cycle drives `ram_raddr` with the current source address and registers `ram_q` into a data register.
  - From the second RUN cycle onward, `ram_we` writes the data register to the previous cycle's destination address.
  - For fill, no read is issued and `ram_wdata` = `fill_value`.
  - After `count` reads, go to DRAIN.
- **DRAIN:** issues the final write, then goes to DONE.
- **DONE:** `done` = 1 for one cycle, then return to IDLE.
- `ram_en` = `busy`. `ram_we` is never high outside RUN and DRAIN.
- `start` is ignored outside IDLE. A `start` in the DONE cycle is lost.
- A read and a write in the same cycle never target the same word, given the direction rule above. The registered read value is the pre-write contents.
- Reset mid-operation: all outputs return to 0 immediately and the FSM goes to IDLE. RAM contents are left partially updated, and no `done` is produced.

## Timing

- Reset values are 0 for `busy`, `done`, `err`, `ram_en`, `ram_we`, `ram_raddr`, `ram_waddr` and `ram_wdata`.
- For a valid command of N words accepted at edge 0:
  - RUN occupies cycles 1 to N.
  - Writes occur in cycles 2 to N+1, with DRAIN in cycle N+1.
  - `done` is high in cycle N+2.
  - `busy` is high for N+1 cycles.
- Throughput is one word per cycle.
- For a zero-length or rejected command, `done` is high in cycle 1 and `busy` never rises.
- The next command can be accepted in the cycle after `done`.

## Configuration

- `RAM_MOVER_FILL_EN`
  - **Defined:** `op` = 1 performs a fill as described above.
  - **Undefined:** the fill datapath is absent and `fill_value` is ignored. `op` = 1 is rejected with `done` and `err` = 1 in cycle 1, with no RAM access.
  - Copy behaviour is identical either way.

## Structure

- Package `ram_mover_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the op codes `OP_COPY` = 0 and `OP_FILL` = 1;
  - the default `LEN`.
- Sub-module `ram_mover_addr_gen`: a loadable 32-bit up/down address counter with a remaining-words counter and a `last` flag. It is instantiated twice, once for source and once for destination.

## Test plan

- Copy src=0, dst=100, count=4 over mem[0..3] = 1,2,3,4 -> mem[100..103] = 1,2,3,4; `done` in cycle 6; `busy` high for 5 cycles.
- Overlapping copy src=10, dst=12, count=4 over mem[10..13] = A,B,C,D -> mem[12..15] = A,B,C,D (descending). Same with src=12, dst=10 -> mem[10..13] = the original mem[12..15].
- Fill dst=1020, count=4, value 0xDEADBEEF with `RAM_MOVER_FILL_EN` -> mem[1020..1023] all 0xDEADBEEF. Without the macro -> `done` and `err` in cycle 1, memory unchanged.
- Copy dst=1022, count=4 -> `done` and `err` in cycle 1; `ram_we` never high. Count=0 -> `done` in cycle 1 with `err` = 0.
- Assert `resetn` low during RUN of a 16-word copy -> all outputs 0 asynchronously, no `done`. After release, a new command completes normally.
- `start` held high through a command -> exactly one command is executed; the next is accepted the cycle after `done`.
